// File: rtl/div_seq_param.sv
// div_seq_param: multi-cycle restoring divider, one quotient bit per clock.
//
// Ports
//   clk    in   system clock, rising edge
//   rst    in   asynchronous reset, active-low
//   start  in   request; honoured in IDLE and FIN, ignored while running
//   D      in   [W-1:0] dividend, captured on the accepting edge
//   d      in   [W-1:0] divisor, captured on the accepting edge
//   busy   out  high while a division is in progress
//   done   out  one-cycle pulse when q/r/dbz become valid
//   q      out  [W-1:0] quotient, held until the next result
//   r      out  [W-1:0] remainder, held until the next result
//   dbz    out  divide-by-zero flag, valid with done and held with q/r
//
// Configuration macro: DIV_SIGNED_EN selects two's-complement operands and
// results (truncation toward zero). Undefined gives a purely unsigned divider.
//
// Timing: the accepting edge loads W into the counter. W edges each retire
// one quotient bit, and one more edge registers the result and enters FIN.
// A zero divisor loads the counter with 0, so FIN follows one edge after
// accept and busy never rises.

module div_seq_param #(
  parameter int unsigned W  = 8,
  parameter int unsigned CW = $clog2(W + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] D,
  input  logic [W-1:0] d,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] q,
  output logic [W-1:0] r,
  output logic         dbz
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  rem_q, rem_d;   // partial remainder
  logic [W-1:0]  dvd_q, dvd_d;   // dividend shifting out, quotient shifting in
  logic [W-1:0]  dvs_q, dvs_d;   // divisor magnitude
  logic          zero_q, zero_d; // current operation has a zero divisor
  logic [W-1:0]  q_q, q_d;
  logic [W-1:0]  r_q, r_d;
  logic          dbz_q, dbz_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

`ifdef DIV_SIGNED_EN
  logic          negq_q, negq_d; // quotient negated when operand signs differ
  logic          negr_q, negr_d; // remainder follows the dividend sign
`endif

  logic [W-1:0]  mag_dvd;
  logic [W-1:0]  mag_dvs;
  logic          zero_in;
  logic [W:0]    rem_sh;
  logic [W:0]    diff;

  // Operand magnitudes presented to the unsigned core.
  always_comb begin
`ifdef DIV_SIGNED_EN
    mag_dvd = D[W-1] ? (~D + W'(1)) : D;
    mag_dvs = d[W-1] ? (~d + W'(1)) : d;
`else
    mag_dvd = D;
    mag_dvs = d;
`endif
    zero_in = (d == '0);
  end

  // One restoring step; W+1 bits so the trial subtraction cannot overflow.
  always_comb begin
    rem_sh = {rem_q, dvd_q[W-1]};
    diff   = rem_sh - {1'b0, dvs_q};
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    zero_d  = zero_q;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;
`ifdef DIV_SIGNED_EN
    negq_d  = negq_q;
    negr_d  = negr_q;
`endif

    case (state_q)
      IDLE, FIN: begin
        if (start) begin
          state_d = RUN;
          zero_d  = zero_in;
          rem_d   = '0;
          dvs_d   = mag_dvs;
          // A zero divisor keeps the raw dividend as the remainder result.
          dvd_d   = zero_in ? D : mag_dvd;
          cnt_d   = zero_in ? '0 : CW'(W);
`ifdef DIV_SIGNED_EN
          negq_d  = D[W-1] ^ d[W-1];
          negr_d  = D[W-1];
`endif
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
          dvd_d = {dvd_q[W-2:0], ~diff[W]};
          rem_d = diff[W] ? rem_sh[W-1:0] : diff[W-1:0];
        end else begin
          state_d = FIN;
          if (zero_q) begin
            q_d   = '1;
            r_d   = dvd_q;
            dbz_d = 1'b1;
          end else begin
`ifdef DIV_SIGNED_EN
            q_d   = negq_q ? (~dvd_q + W'(1)) : dvd_q;
            r_d   = negr_q ? (~rem_q + W'(1)) : rem_q;
`else
            q_d   = dvd_q;
            r_d   = rem_q;
`endif
            dbz_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN) && !zero_d;
    done_d = (state_d == FIN);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      zero_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef DIV_SIGNED_EN
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      zero_q  <= zero_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef DIV_SIGNED_EN
      negq_q  <= negq_d;
      negr_q  <= negr_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign q    = q_q;
  assign r    = r_q;
  assign dbz  = dbz_q;

endmodule

// File: tb/tb_div_seq_param.sv
// Directed bench for div_seq_param: a W=4 instance for the directed and
// boundary vectors, and a W=8 instance for the wide sweep (unsigned build).
module tb_div_seq_param;

  logic       clk;
  logic       rst;

  logic       start4, busy4, done4, dbz4;
  logic [3:0] D4, d4, q4, r4;

  logic       start8, busy8, done8, dbz8;
  logic [7:0] D8, d8, q8, r8;

  int tests;
  int fails;

  div_seq_param #(.W(4)) u_div4 (
    .clk(clk), .rst(rst), .start(start4), .D(D4), .d(d4),
    .busy(busy4), .done(done4), .q(q4), .r(r4), .dbz(dbz4)
  );

  div_seq_param #(.W(8)) u_div8 (
    .clk(clk), .rst(rst), .start(start8), .D(D8), .d(d8),
    .busy(busy8), .done(done8), .q(q8), .r(r8), .dbz(dbz8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Single start pulse on the W=4 instance; lat counts edges from accept to done.
  task automatic run4(input logic [3:0] a, input logic [3:0] b,
                      output int lat, output logic busy_seen, output logic busy_last);
    D4 = a; d4 = b; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    lat = 0;
    busy_seen = busy4;
    busy_last = busy4;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (done4) break;
      busy_seen = busy_seen | busy4;
      busy_last = busy4;
    end
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, output int lat);
    D8 = a; d8 = b; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (done8) break;
    end
  endtask

  initial begin
    int   lat;
    logic bs, bl, saw_done;
    logic [7:0] a, b;
    tests = 0; fails = 0;
    rst = 1'b0;
    start4 = 1'b0; D4 = '0; d4 = '0;
    start8 = 1'b0; D8 = '0; d8 = '0;

    #12;
    check("rst_busy", busy4, 0);
    check("rst_done", done4, 0);
    check("rst_q",    q4,    0);
    check("rst_r",    r4,    0);
    check("rst_dbz",  dbz4,  0);
    rst = 1'b1;
    @(posedge clk); #1;

`ifndef DIV_SIGNED_EN
    run4(4'd15, 4'd2, lat, bs, bl);
    check("15/2 lat", lat, 5);
    check("15/2 busy_before_done", bl, 1);
    check("15/2 busy_at_done", busy4, 0);
    check("15/2 q", q4, 7);
    check("15/2 r", r4, 1);
    check("15/2 dbz", dbz4, 0);
    @(posedge clk); #1;
    check("done_pulse_one_cycle", done4, 0);
    repeat (3) @(posedge clk);
    #1;
    check("hold_q", q4, 7);
    check("hold_r", r4, 1);

    run4(4'd0, 4'd2, lat, bs, bl);
    check("0/2 q", q4, 0);
    check("0/2 r", r4, 0);
    run4(4'd8, 4'd8, lat, bs, bl);
    check("8/8 q", q4, 1);
    check("8/8 r", r4, 0);
    run4(4'd3, 4'd6, lat, bs, bl);
    check("3/6 q", q4, 0);
    check("3/6 r", r4, 3);
    run4(4'd15, 4'd1, lat, bs, bl);
    check("15/1 q", q4, 15);
    check("15/1 r", r4, 0);
    check("15/1 dbz", dbz4, 0);

    // Divide by zero, then a normal divide clears the flag.
    run4(4'd9, 4'd0, lat, bs, bl);
    check("9/0 lat", lat, 1);
    check("9/0 busy_never", bs, 0);
    check("9/0 q", q4, 15);
    check("9/0 r", r4, 9);
    check("9/0 dbz", dbz4, 1);
    run4(4'd9, 4'd3, lat, bs, bl);
    check("9/3 q", q4, 3);
    check("9/3 r", r4, 0);
    check("9/3 dbz", dbz4, 0);

    // Start held through RUN with operands changing; re-accept only in FIN.
    D4 = 4'd13; d4 = 4'd4; start4 = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 2) begin D4 = 4'd2; d4 = 4'd1; end
      if (done4) break;
    end
    check("held lat", lat, 5);
    check("held q", q4, 3);
    check("held r", r4, 1);
    @(posedge clk); #1;
    start4 = 1'b0;
    check("b2b busy", busy4, 1);
    check("b2b q_holds", q4, 3);
    lat = 1;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (done4) break;
    end
    check("b2b lat", lat, 6);
    check("b2b q", q4, 2);
    check("b2b r", r4, 0);

    // Asynchronous reset mid-division.
    D4 = 4'd14; d4 = 4'd3; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("abort busy", busy4, 0);
    check("abort done", done4, 0);
    check("abort q", q4, 0);
    check("abort r", r4, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    saw_done = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      saw_done = saw_done | done4;
    end
    check("abort no_done", saw_done, 0);
    run4(4'd14, 4'd3, lat, bs, bl);
    check("14/3 lat", lat, 5);
    check("14/3 q", q4, 4);
    check("14/3 r", r4, 2);

    // Wide unsigned sweep on the W=8 instance.
    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(1, 255));
      if (i == 0) begin a = 8'd255; b = 8'd1; end
      run8(a, b, lat);
      check("w8 lat", lat, 9);
      check("w8 identity", 32'(q8) * 32'(b) + 32'(r8), 32'(a));
      check("w8 r_lt_d", 32'(r8 < b), 1);
      check("w8 dbz", dbz8, 0);
    end
`else
    run4(4'b1001, 4'd2, lat, bs, bl);
    check("-7/2 lat", lat, 5);
    check("-7/2 q", q4, 4'b1101);
    check("-7/2 r", r4, 4'b1111);
    check("-7/2 dbz", dbz4, 0);
    run4(4'd7, 4'b1110, lat, bs, bl);
    check("7/-2 q", q4, 4'b1101);
    check("7/-2 r", r4, 4'b0001);
    run4(4'b1000, 4'b1111, lat, bs, bl);
    check("-8/-1 q", q4, 4'b1000);
    check("-8/-1 r", r4, 0);
    check("-8/-1 dbz", dbz4, 0);
    run4(4'b1000, 4'd0, lat, bs, bl);
    check("-8/0 lat", lat, 1);
    check("-8/0 busy_never", bs, 0);
    check("-8/0 q", q4, 4'b1111);
    check("-8/0 r", r4, 4'b1000);
    check("-8/0 dbz", dbz4, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
